vedic_mac_accum: RTL and testbench
==================================

Name: vedic_mac_accum

Overview:
Downstream stage of the 4x4 Vedic multiplier. It consumes the 8-bit product stream over a valid/ready handshake and accumulates a programmed number of products into a wide accumulator. It then presents the sum, with a sticky overflow flag, over a second valid/ready handshake. The result is a multiply-accumulate (dot-product) path in front of the TinyTapeout output pins.

Parameters:
ACC_W, 16, accumulator and result width in bits (legal range 9..32).
LEN_W, 4, width of the length field; len = 0 encodes 2**LEN_W products.

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  global enable; when low, all state freezes and both handshakes are masked.
start  input  1  single-cycle request to begin an accumulation; honoured only in IDLE.
len  input  LEN_W  number of products to accumulate; sampled on an accepted start.
prod_valid  input  1  upstream product valid.
prod_data  input  8  upstream product (unsigned a*b, 0..225).
prod_ready  output  1  block can accept a product this cycle.
res_valid  output  1  result available.
res_data  output  ACC_W  accumulated sum (modulo 2**ACC_W).
res_ovf  output  1  sticky flag; set if any addition carried out of ACC_W bits.
busy  output  1  high in ACC or HOLD.

Behaviour:
- Reset (async, rst_n low): state = IDLE, acc = 0, cnt = 0, ovf = 0. Outputs: prod_ready = 0, res_valid = 0, res_data = 0, res_ovf = 0, busy = 0. Reset asserted mid-operation aborts the operation; a partially accumulated sum is discarded and never presented.
- Masking: prod_ready = (state == ACC) & ena; res_valid = (state == HOLD) & ena. These are combinational masks over registered state.
- Handshakes: a product is accepted when prod_valid & prod_ready. A result is taken when res_valid & res_ready.
- ena low: no register changes at all; start, prod_valid and res_ready are ignored.
- State machine:
  - IDLE: prod_ready = 0.
    - start & ena: acc <= 0, ovf <= 0, cnt <= (len == 0 ? 2**LEN_W : len), go to ACC.
  - ACC: on each accepted product:
    - {carry, acc} <= acc + zero-extended prod_data.
    - ovf <= ovf | carry.
    - cnt <= cnt - 1.
    - If cnt == 1 at acceptance, go to HOLD.
    - Cycles with prod_valid low insert bubbles and change nothing.
  - HOLD: res_valid high, res_data = acc, res_ovf = ovf. Both values are stable while res_ready is low.
    - When the result is taken, go to IDLE.
    - acc and ovf are retained until the next accepted start.
- Latency: res_valid rises in the cycle after the final product handshake. Minimum total latency is N+1 cycles from start to res_valid, for N products with prod_valid held high.
- Accepting a new start: start is ignored in ACC and HOLD (no restart, no queueing). A start that is coincident with the result handshake in HOLD is also ignored. The earliest accepted start is the cycle after the block returns to IDLE.
- Counter width: cnt is LEN_W+1 bits so it can hold 2**LEN_W.
- res_data and res_ovf read the registered acc and ovf in every state. busy = (state != IDLE), not masked by ena.

Test Plan:
- Basic accumulate: reset; start with len=3; present products 225, 225, 225 back-to-back. Required: prod_ready high for 3 cycles; res_valid one cycle after the third handshake; res_data=675 (0x02A3); res_ovf=0.
- Full length (len=0): 16 products of 225. Required: exactly 16 products accepted, prod_ready low afterwards, res_data=3600, res_ovf=0.
- Overflow (ACC_W=10): start with len=5; present 5 products of 225 (true sum 1125). Required: res_data=101, res_ovf=1. A following run with len=1 and product 4 gives res_data=4, res_ovf=0.
- Backpressure and bubbles:
  - Stimulus: len=2; prod_valid toggles 1,0,1 with products 6 and 9; res_ready held low for 4 cycles.
  - Required: res_data=15 stays stable with res_valid high for all 4 cycles; state returns to IDLE the cycle after res_ready rises.
  - A start pulsed during ACC is ignored, and the sum remains 15.
- ena gating: drop ena for 3 cycles in ACC while prod_valid is high. Required: prod_ready=0, no products accepted, cnt/acc unchanged; accumulation resumes when ena returns and the final sum is correct.
- Reset mid-operation: assert rst_n=0 after 2 of 4 products. Required: immediately res_valid=0, busy=0, res_data=0; a new run with len=1 and product 49 gives res_data=49.

Source files
------------

// File: rtl/vedic_mac_accum_if.sv
// Product-in / result-out handshake bundle for the Vedic MAC accumulator.
// The master side produces products and consumes results; the slave side
// is the accumulator itself.
interface vedic_mac_accum_if #(
  parameter int ACC_W = 16
);
  logic             prod_valid;
  logic             prod_ready;
  logic [7:0]       prod_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;

  modport master (
    output prod_valid, prod_data, res_ready,
    input  prod_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  prod_valid, prod_data, res_ready,
    output prod_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/vedic_mac_accum.sv
// Multiply-accumulate back end for the 4x4 Vedic multiplier.
// Sums a programmed number of 8-bit products into an ACC_W-bit register,
// then holds the sum and a sticky carry-out flag until the result is taken.
//
//   state | meaning
//   IDLE  | waiting for start; last result (acc/ovf) still readable
//   ACC   | accepting products, cnt counts remaining products down to 1
//   HOLD  | result presented, waiting for res_ready
module vedic_mac_accum #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  vedic_mac_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  // len == 0 encodes a full run of 2**LEN_W products, hence the extra cnt bit.
  localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_t           state_q, state_nx;
  logic [ACC_W-1:0] acc_q, acc_nx;
  logic [LEN_W:0]   cnt_q, cnt_nx;
  logic             ovf_q, ovf_nx;
  logic [ACC_W:0]   sum;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.prod_data};

  // Register all state; ena low leaves the next-state values equal to current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      acc_q   <= acc_nx;
      cnt_q   <= cnt_nx;
      ovf_q   <= ovf_nx;
    end
  end

  // Next-state and datapath updates, all gated by ena.
  always_comb begin
    state_nx = state_q;
    acc_nx   = acc_q;
    cnt_nx   = cnt_q;
    ovf_nx   = ovf_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            cnt_nx   = (len == '0) ? CNT_FULL : {1'b0, len};
            state_nx = ACC;
          end
        end
        ACC: begin
          if (bus.prod_valid) begin
            acc_nx = sum[ACC_W-1:0];
            ovf_nx = ovf_q | sum[ACC_W];
            cnt_nx = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_nx = HOLD;
          end
        end
        HOLD: begin
          // A start coincident with the result handshake is dropped here.
          if (bus.res_ready) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Handshake outputs are ena-masked views of registered state.
  assign bus.prod_ready = (state_q == ACC) & ena;
  assign bus.res_valid  = (state_q == HOLD) & ena;
  assign bus.res_data   = acc_q;
  assign bus.res_ovf    = ovf_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Bench for vedic_mac_accum: a 16-bit and a 10-bit instance driven in lockstep,
// compared against a transaction-level sum model.
module tb_vedic_mac_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = '0;
  logic       busy16, busy10;

  int n_checks = 0;
  int n_errors = 0;
  int q[$];
  int vpat[$];

  vedic_mac_accum_if #(.ACC_W(16)) bus16 ();
  vedic_mac_accum_if #(.ACC_W(10)) bus10 ();

  vedic_mac_accum #(.ACC_W(16), .LEN_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .len(len),
    .busy(busy16), .bus(bus16.slave)
  );

  vedic_mac_accum #(.ACC_W(10), .LEN_W(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .len(len),
    .busy(busy10), .bus(bus10.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_prod(input logic v, input logic [7:0] d);
    bus16.prod_valid = v;
    bus16.prod_data  = d;
    bus10.prod_valid = v;
    bus10.prod_data  = d;
  endtask

  task automatic drive_rr(input logic r);
    bus16.res_ready = r;
    bus10.res_ready = r;
  endtask

  task automatic check_result(input string tag, input longint s);
    check({tag, "_data16"}, 64'(bus16.res_data), 64'(s % 65536));
    check({tag, "_ovf16"},  64'(bus16.res_ovf),  64'(s >= 65536));
    check({tag, "_data10"}, 64'(bus10.res_data), 64'(s % 1024));
    check({tag, "_ovf10"},  64'(bus10.res_ovf),  64'(s >= 1024));
  endtask

  // One complete accumulation of the products in q, with optional bubbles,
  // ena drops, start noise and result backpressure.
  task automatic run(input int l, input int bubble_pct, input int ena_pct,
                     input int bp, input bit noise);
    int     n;
    int     idx;
    int     cyc;
    longint s;
    logic   v;
    n = (l == 0) ? 16 : l;
    s = 0;
    foreach (q[i]) s += q[i];
    @(negedge clk);
    ena = 1'b1; start = 1'b1; len = 4'(l);
    @(negedge clk);
    start = 1'b0;
    #1 check("busy_after_start", 64'(busy16), 64'(1));
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 500) begin
      ena = ($urandom_range(99) < ena_pct) ? 1'b0 : 1'b1;
      if (vpat.size() > 0) v = 1'(vpat.pop_front());
      else v = ($urandom_range(99) < bubble_pct) ? 1'b0 : 1'b1;
      drive_prod(v, 8'(q[idx]));
      start = noise && ($urandom_range(3) == 0);
      len = 4'($urandom_range(15));
      #1;
      check("prod_ready16", 64'(bus16.prod_ready), 64'(ena));
      check("prod_ready10", 64'(bus10.prod_ready), 64'(ena));
      check("res_valid_early", 64'(bus16.res_valid), 64'(0));
      if (v && ena) idx++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) check("feed_timeout", 64'(idx), 64'(n));
    drive_prod(1'b0, 8'h00);
    ena = 1'b1; start = 1'b0; drive_rr(1'b0);
    #1;
    check("res_valid_latency", 64'(bus16.res_valid), 64'(1));
    check("prod_ready_hold", 64'(bus16.prod_ready), 64'(0));
    check_result("hold", s);
    for (int i = 0; i < bp; i++) begin
      start = noise;
      @(negedge clk);
      #1;
      check("res_valid_bp", 64'(bus16.res_valid), 64'(1));
      check("busy_bp", 64'(busy10), 64'(1));
      check_result("bp", s);
    end
    drive_rr(1'b1);
    start = noise;
    @(negedge clk);
    drive_rr(1'b0);
    start = 1'b0;
    #1;
    check("busy_after_take", 64'(busy16), 64'(0));
    check("res_valid_after_take", 64'(bus10.res_valid), 64'(0));
    check_result("retained", s);
  endtask

  initial begin
    drive_prod(1'b0, 8'h00);
    drive_rr(1'b0);
    ena = 1'b1;
    #2;
    check("rst_prod_ready", 64'(bus16.prod_ready), 64'(0));
    check("rst_res_valid", 64'(bus16.res_valid), 64'(0));
    check("rst_res_data", 64'(bus16.res_data), 64'(0));
    check("rst_res_ovf", 64'(bus16.res_ovf), 64'(0));
    check("rst_busy", 64'(busy16), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: three max products back-to-back.
    q = {225, 225, 225};
    run(3, 0, 0, 0, 0);

    // Full length run encoded by len = 0.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(225);
    run(0, 0, 0, 1, 0);

    // Overflow on the 10-bit instance, then a clean run clears the flag.
    q = {225, 225, 225, 225, 225};
    run(5, 0, 0, 0, 0);
    q = {4};
    run(1, 0, 0, 0, 0);

    // Bubbles, backpressure and ignored starts.
    q = {6, 9};
    vpat = {1, 0, 1};
    run(2, 0, 0, 4, 1);

    // ena dropped often during accumulation.
    q = {200, 17, 99, 0, 225, 31};
    run(6, 10, 40, 2, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; len = 4'd4;
    @(negedge clk);
    start = 1'b0;
    drive_prod(1'b1, 8'd100);
    @(negedge clk);
    @(negedge clk);
    drive_prod(1'b0, 8'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", 64'(bus16.res_valid), 64'(0));
    check("midrst_busy", 64'(busy16), 64'(0));
    check("midrst_res_data", 64'(bus16.res_data), 64'(0));
    check("midrst_res_data10", 64'(bus10.res_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    q = {49};
    run(1, 0, 0, 0, 0);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      int l;
      int n;
      l = $urandom_range(15);
      n = (l == 0) ? 16 : l;
      q = {};
      for (int i = 0; i < n; i++) q.push_back($urandom_range(225));
      run(l, 25, 15, $urandom_range(3), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
